// File: rtl/gpa_fhdo_pkg.sv
// Shared definitions for the GPA-FHDO gradient SPI link (master and DAC80504 responder).
package gpa_fhdo_pkg;

  localparam int unsigned FrameWidth = 24;

  localparam logic [3:0] AddrNop     = 4'h0;
  localparam logic [3:0] AddrDevId   = 4'h1;
  localparam logic [3:0] AddrSync    = 4'h2;
  localparam logic [3:0] AddrTrigger = 4'h5;
  localparam logic [3:0] AddrDac0    = 4'h8;
  localparam logic [3:0] AddrDac1    = 4'h9;
  localparam logic [3:0] AddrDac2    = 4'hA;
  localparam logic [3:0] AddrDac3    = 4'hB;

  localparam logic [3:0]  SoftRstCode = 4'b1010;
  localparam int unsigned SoftLdacBit = 4;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StShift  = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;
  localparam logic [1:0] StErr    = 2'd3;

  typedef struct packed {
    logic        rw;
    logic [2:0]  rsvd;
    logic [3:0]  addr;
    logic [15:0] data;
  } frame_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with single-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
    prev_d = sync_q[Stages-1];
  end

  // Resetting to 0 means a line held low across reset never produces a falling edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = sync_q[Stages-1] & ~prev_q;
  assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/dac80504_spi_slave.sv
// DAC80504-compatible SPI responder: decodes 24-bit frames, drives four DAC codes with
// LDAC-synchronous update, and shifts readback data out on sdo.
module dac80504_spi_slave
  import gpa_fhdo_pkg::*;
#(
  parameter logic [15:0] DEVICE_ID   = 16'h0A14,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sclk,
  input  logic        csn,
  input  logic        sdi,
  input  logic        ldacn,
  output logic        sdo,
  output logic [15:0] vout0,
  output logic [15:0] vout1,
  output logic [15:0] vout2,
  output logic [15:0] vout3,
  output logic        frame_err_o,
  output logic [15:0] frame_cnt_o
);

  localparam logic [4:0] FrameBits = 5'(FrameWidth);

  logic sclk_q, sclk_rise, sclk_fall;
  logic csn_q, csn_rise, csn_fall;
  logic sdi_q, sdi_rise, sdi_fall;
  logic ldacn_q, ldacn_rise, ldacn_fall;

  spi_sync_edge #(.Stages(SYNC_STAGES)) u_sync_sclk (
    .clk_i(clk), .rst_ni(resetn), .d_i(sclk),
    .q_o(sclk_q), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync_edge #(.Stages(SYNC_STAGES)) u_sync_csn (
    .clk_i(clk), .rst_ni(resetn), .d_i(csn),
    .q_o(csn_q), .rise_o(csn_rise), .fall_o(csn_fall)
  );
  spi_sync_edge #(.Stages(SYNC_STAGES)) u_sync_sdi (
    .clk_i(clk), .rst_ni(resetn), .d_i(sdi),
    .q_o(sdi_q), .rise_o(sdi_rise), .fall_o(sdi_fall)
  );
  spi_sync_edge #(.Stages(SYNC_STAGES)) u_sync_ldacn (
    .clk_i(clk), .rst_ni(resetn), .d_i(ldacn),
    .q_o(ldacn_q), .rise_o(ldacn_rise), .fall_o(ldacn_fall)
  );

  logic [1:0]       state_q, state_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [23:0]      rx_q, rx_d;
  logic [23:0]      tx_q, tx_d;
  logic             pend_q, pend_d;
  logic [3:0]       rd_addr_q, rd_addr_d;
  logic [3:0]       sync_en_q, sync_en_d;
  logic [3:0][15:0] dbuf_q, dbuf_d;
  logic [3:0][15:0] vout_q, vout_d;
  logic [15:0]      cnt_q, cnt_d;

  frame_t      frame;
  logic [15:0] rd_data;
  logic        soft_ldac, soft_rst;

  assign frame = rx_q;

  logic unused_sync;
  assign unused_sync = ^{sclk_q, csn_q, sdi_rise, sdi_fall, ldacn_q, ldacn_rise, frame.rsvd};

  always_comb begin
    rd_data = '0;
    case (rd_addr_q)
      AddrDevId: rd_data = DEVICE_ID;
      AddrSync:  rd_data = {12'h000, sync_en_q};
      AddrDac0:  rd_data = dbuf_q[0];
      AddrDac1:  rd_data = dbuf_q[1];
      AddrDac2:  rd_data = dbuf_q[2];
      AddrDac3:  rd_data = dbuf_q[3];
      default:   rd_data = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    pend_d    = pend_q;
    rd_addr_d = rd_addr_q;
    sync_en_d = sync_en_q;
    dbuf_d    = dbuf_q;
    vout_d    = vout_q;
    cnt_d     = cnt_q;
    soft_ldac = 1'b0;
    soft_rst  = 1'b0;

    case (state_q)
      StIdle: begin
        if (csn_fall) begin
          state_d   = StShift;
          bit_cnt_d = '0;
          tx_d      = pend_q ? {8'h00, rd_data} : 24'h0;
          pend_d    = 1'b0;
        end
      end
      StShift: begin
        if (sclk_fall) begin
          if (bit_cnt_q < FrameBits) rx_d = {rx_q[22:0], sdi_q};
          if (bit_cnt_q != 5'h1F) bit_cnt_d = bit_cnt_q + 5'd1;
        end
        // MSB is preloaded, so the first rising edge must not shift it away.
        if (sclk_rise && bit_cnt_q != 5'd0) tx_d = {tx_q[22:0], 1'b0};
        if (csn_rise) state_d = (bit_cnt_q == FrameBits) ? StCommit : StErr;
      end
      StCommit: begin
        state_d = StIdle;
        cnt_d   = cnt_q + 16'd1;
        if (frame.rw) begin
          pend_d    = 1'b1;
          rd_addr_d = frame.addr;
        end else if (frame.addr == AddrSync) begin
          sync_en_d = frame.data[3:0];
        end else if (frame.addr == AddrTrigger) begin
          soft_ldac = frame.data[SoftLdacBit];
          soft_rst  = (frame.data[3:0] == SoftRstCode);
        end else if (frame.addr[3:2] == 2'b10) begin
          dbuf_d[frame.addr[1:0]] = frame.data;
          if (!sync_en_q[frame.addr[1:0]]) vout_d[frame.addr[1:0]] = frame.data;
        end
      end
      default: state_d = StIdle;
    endcase

    // Load uses the post-write buffers so a coincident DAC write lands first.
    if (ldacn_fall || soft_ldac) begin
      for (int n = 0; n < 4; n++) begin
        if (sync_en_q[n]) vout_d[n] = dbuf_d[n];
      end
    end

    if (soft_rst) begin
      sync_en_d = '0;
      dbuf_d    = '0;
      vout_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      pend_q    <= 1'b0;
      rd_addr_q <= '0;
      sync_en_q <= '0;
      dbuf_q    <= '0;
      vout_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      pend_q    <= pend_d;
      rd_addr_q <= rd_addr_d;
      sync_en_q <= sync_en_d;
      dbuf_q    <= dbuf_d;
      vout_q    <= vout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sdo         = tx_q[23];
  assign vout0       = vout_q[0];
  assign vout1       = vout_q[1];
  assign vout2       = vout_q[2];
  assign vout3       = vout_q[3];
  assign frame_err_o = (state_q == StErr);
  assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_dac80504_spi_slave.sv
// Bench for dac80504_spi_slave: directed vector table, hand-timed corner cases, and
// randomized frames checked against a register-level reference model.
module tb_dac80504_spi_slave;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sclk = 1'b0;
  logic        csn = 1'b1;
  logic        sdi = 1'b0;
  logic        ldacn = 1'b1;
  logic        sdo;
  logic [15:0] vout0, vout1, vout2, vout3;
  logic        frame_err_o;
  logic [15:0] frame_cnt_o;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  dac80504_spi_slave #(.DEVICE_ID(16'h0A14), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .sclk(sclk), .csn(csn), .sdi(sdi), .ldacn(ldacn),
    .sdo(sdo), .vout0(vout0), .vout1(vout1), .vout2(vout2), .vout3(vout3),
    .frame_err_o(frame_err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err_o) err_seen <= err_seen + 1;

  typedef struct {
    logic [23:0] word;
    int          nbits;
    bit          ldac;
    logic [63:0] vout;
    logic [15:0] cnt;
    logic [23:0] rd;
    int          errs;
  } vec_t;

  vec_t tbl[19];

  // Reference model: register-level view of the device.
  logic [15:0] m_buf[4];
  logic [15:0] m_vout[4];
  logic [3:0]  m_sync;
  logic [15:0] m_cnt;
  bit          m_pend;
  logic [3:0]  m_addr;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_vout();
    return {vout3, vout2, vout1, vout0};
  endfunction

  task automatic spi_start();
    @(negedge clk);
    csn = 1'b0;
    wait_clk(6);
  endtask

  task automatic spi_bits(input logic [23:0] word, input int from, input int to,
                          inout logic [23:0] rd);
    for (int i = from; i < to; i++) begin
      sdi  = (i < 24) ? word[23-i] : 1'($urandom);
      sclk = 1'b1;
      wait_clk(4);
      if (i < 24) rd[23-i] = sdo;
      sclk = 1'b0;
      wait_clk(4);
    end
  endtask

  task automatic spi_end();
    wait_clk(2);
    csn = 1'b1;
    wait_clk(8);
  endtask

  task automatic spi_frame(input logic [23:0] word, input int nbits, output logic [23:0] rd);
    logic [23:0] r;
    r = '0;
    spi_start();
    spi_bits(word, 0, nbits, r);
    spi_end();
    rd = r;
  endtask

  task automatic pulse_ldac();
    @(negedge clk);
    ldacn = 1'b0;
    wait_clk(4);
    ldacn = 1'b1;
    wait_clk(6);
  endtask

  function automatic logic [15:0] m_reg(input logic [3:0] a);
    if (a == 4'h1) return 16'h0A14;
    if (a == 4'h2) return {12'h0, m_sync};
    if (a >= 4'h8 && a <= 4'hB) return m_buf[a - 4'h8];
    return 16'h0;
  endfunction

  task automatic m_ldac();
    for (int n = 0; n < 4; n++) if (m_sync[n]) m_vout[n] = m_buf[n];
  endtask

  task automatic m_frame(input logic [23:0] w, input int nb, output logic [23:0] exp_rd);
    logic [3:0]  a;
    logic [15:0] d;
    exp_rd = m_pend ? {8'h00, m_reg(m_addr)} : 24'h0;
    m_pend = 0;
    if (nb != 24) return;
    a = w[19:16];
    d = w[15:0];
    m_cnt = m_cnt + 16'd1;
    if (w[23]) begin
      m_pend = 1;
      m_addr = a;
    end else if (a == 4'h2) begin
      m_sync = d[3:0];
    end else if (a == 4'h5) begin
      if (d[3:0] == 4'b1010) begin
        m_sync = 0;
        for (int n = 0; n < 4; n++) begin
          m_buf[n]  = 0;
          m_vout[n] = 0;
        end
      end else if (d[4]) begin
        m_ldac();
      end
    end else if (a >= 4'h8 && a <= 4'hB) begin
      m_buf[a - 4'h8] = d;
      if (!m_sync[a - 4'h8]) m_vout[a - 4'h8] = d;
    end
  endtask

  initial begin
    logic [23:0] rd;
    logic [23:0] exp_rd;
    int          e0;
    logic [3:0]  addr_pool[10];

    tbl[0]  = '{24'h02_0005, 24, 0, 64'h0000_0000_1234_0000, 16'd2,  24'h0, 0};
    tbl[1]  = '{24'h08_AAAA, 24, 0, 64'h0000_0000_1234_0000, 16'd3,  24'h0, 0};
    tbl[2]  = '{24'h0A_5555, 24, 1, 64'h0000_5555_1234_AAAA, 16'd4,  24'h0, 0};
    tbl[3]  = '{24'h08_1111, 24, 0, 64'h0000_5555_1234_AAAA, 16'd5,  24'h0, 0};
    tbl[4]  = '{24'h0A_2222, 24, 0, 64'h0000_5555_1234_AAAA, 16'd6,  24'h0, 0};
    tbl[5]  = '{24'h05_0010, 24, 0, 64'h0000_2222_1234_1111, 16'd7,  24'h0, 0};
    tbl[6]  = '{24'h81_0000, 24, 0, 64'h0000_2222_1234_1111, 16'd8,  24'h0, 0};
    tbl[7]  = '{24'h00_0000, 24, 0, 64'h0000_2222_1234_1111, 16'd9,  24'h000A14, 0};
    tbl[8]  = '{24'h00_0000, 24, 0, 64'h0000_2222_1234_1111, 16'd10, 24'h0, 0};
    tbl[9]  = '{24'h0B_3333, 23, 0, 64'h0000_2222_1234_1111, 16'd10, 24'h0, 1};
    tbl[10] = '{24'h0B_3333, 25, 0, 64'h0000_2222_1234_1111, 16'd10, 24'h0, 1};
    tbl[11] = '{24'h0B_3333, 0,  0, 64'h0000_2222_1234_1111, 16'd10, 24'h0, 1};
    tbl[12] = '{24'h0B_3333, 24, 0, 64'h3333_2222_1234_1111, 16'd11, 24'h0, 0};
    tbl[13] = '{24'h05_000A, 24, 0, 64'h0000_0000_0000_0000, 16'd12, 24'h0, 0};
    tbl[14] = '{24'h82_0000, 24, 0, 64'h0000_0000_0000_0000, 16'd13, 24'h0, 0};
    tbl[15] = '{24'h00_0000, 24, 0, 64'h0000_0000_0000_0000, 16'd14, 24'h0, 0};
    tbl[16] = '{24'h0B_7777, 24, 0, 64'h7777_0000_0000_0000, 16'd15, 24'h0, 0};
    tbl[17] = '{24'h8B_0000, 24, 0, 64'h7777_0000_0000_0000, 16'd16, 24'h0, 0};
    tbl[18] = '{24'h00_0000, 24, 0, 64'h7777_0000_0000_0000, 16'd17, 24'h007777, 0};

    wait_clk(3);
    check("reset vout", dut_vout(), 64'h0);
    check("reset sdo", 64'(sdo), 64'h0);
    check("reset cnt", 64'(frame_cnt_o), 64'h0);
    check("reset err", 64'(frame_err_o), 64'h0);
    resetn = 1'b1;
    wait_clk(4);

    // Write latency: vout changes exactly 4 clk edges after the csn rise.
    rd = '0;
    spi_start();
    spi_bits(24'h09_1234, 0, 24, rd);
    wait_clk(2);
    csn = 1'b1;
    wait_clk(3);
    check("latency early vout1", 64'(vout1), 64'h0);
    wait_clk(1);
    check("latency vout1", 64'(vout1), 64'h1234);
    check("latency cnt", 64'(frame_cnt_o), 64'd1);
    wait_clk(6);

    for (int i = 0; i < 19; i++) begin
      e0 = err_seen;
      spi_frame(tbl[i].word, tbl[i].nbits, rd);
      if (tbl[i].ldac) pulse_ldac();
      check($sformatf("vec%0d vout", i), dut_vout(), tbl[i].vout);
      check($sformatf("vec%0d cnt", i), 64'(frame_cnt_o), 64'(tbl[i].cnt));
      check($sformatf("vec%0d rd", i), 64'(rd), 64'(tbl[i].rd));
      check($sformatf("vec%0d err", i), 64'(err_seen - e0), 64'(tbl[i].errs));
    end

    // Reset in the middle of a DAC3 write; the tail of that frame must be ignored.
    rd = '0;
    spi_start();
    spi_bits(24'h0B_ABCD, 0, 12, rd);
    @(negedge clk);
    resetn = 1'b0;
    wait_clk(3);
    check("midreset vout", dut_vout(), 64'h0);
    check("midreset cnt", 64'(frame_cnt_o), 64'h0);
    resetn = 1'b1;
    wait_clk(4);
    e0 = err_seen;
    spi_bits(24'h0B_ABCD, 12, 24, rd);
    spi_end();
    check("midreset tail vout3", 64'(vout3), 64'h0);
    check("midreset tail err", 64'(err_seen - e0), 64'h0);
    spi_frame(24'h0B_ABCD, 24, rd);
    check("postreset vout", dut_vout(), 64'hABCD_0000_0000_0000);
    check("postreset cnt", 64'(frame_cnt_o), 64'd1);

    m_sync = 0;
    m_cnt  = 1;
    m_pend = 0;
    m_addr = 0;
    for (int n = 0; n < 4; n++) begin
      m_buf[n]  = 0;
      m_vout[n] = 0;
    end
    m_buf[3]  = 16'hABCD;
    m_vout[3] = 16'hABCD;

    addr_pool = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h3, 4'hF};
    for (int k = 0; k < 40; k++) begin
      logic [23:0] w;
      int          nb;
      int          r;
      w[23]    = ($urandom_range(0, 3) == 0);
      w[22:20] = 3'($urandom);
      w[19:16] = addr_pool[$urandom_range(0, 9)];
      w[15:0]  = 16'($urandom);
      r  = $urandom_range(0, 9);
      nb = (r == 0) ? 23 : (r == 1) ? 25 : 24;
      e0 = err_seen;
      spi_frame(w, nb, rd);
      m_frame(w, nb, exp_rd);
      if ($urandom_range(0, 3) == 0) begin
        pulse_ldac();
        m_ldac();
      end
      check($sformatf("rand%0d vout", k), dut_vout(),
            {m_vout[3], m_vout[2], m_vout[1], m_vout[0]});
      check($sformatf("rand%0d cnt", k), 64'(frame_cnt_o), 64'(m_cnt));
      check($sformatf("rand%0d rd", k), 64'(rd), 64'(exp_rd));
      check($sformatf("rand%0d err", k), 64'(err_seen - e0), 64'(nb != 24));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
